// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU-command and branch encodings plus the control bundle
// that travels in the ID/EX control pipeline register.
package ctrl_pkg;

    localparam int CTRL_OPCODE_W   = 6;
    localparam int CTRL_EXE_CMD_W  = 4;
    localparam int CTRL_REG_ADDR_W = 5;

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd5;
    localparam logic [5:0] OP_OR   = 6'd6;
    localparam logic [5:0] OP_NOR  = 6'd7;
    localparam logic [5:0] OP_XOR  = 6'd8;
    localparam logic [5:0] OP_SLA  = 6'd9;
    localparam logic [5:0] OP_SLL  = 6'd10;
    localparam logic [5:0] OP_SRA  = 6'd11;
    localparam logic [5:0] OP_SRL  = 6'd12;
    localparam logic [5:0] OP_ADDI = 6'd32;
    localparam logic [5:0] OP_SUBI = 6'd33;
    localparam logic [5:0] OP_LD   = 6'd36;
    localparam logic [5:0] OP_ST   = 6'd37;
    localparam logic [5:0] OP_BEZ  = 6'd40;
    localparam logic [5:0] OP_BNE  = 6'd41;
    localparam logic [5:0] OP_JMP  = 6'd42;

    localparam logic [3:0] EXE_ADD = 4'b0000;
    localparam logic [3:0] EXE_SUB = 4'b0010;
    localparam logic [3:0] EXE_AND = 4'b0100;
    localparam logic [3:0] EXE_OR  = 4'b0101;
    localparam logic [3:0] EXE_NOR = 4'b0110;
    localparam logic [3:0] EXE_XOR = 4'b0111;
    localparam logic [3:0] EXE_SHL = 4'b1000;
    localparam logic [3:0] EXE_SRA = 4'b1001;
    localparam logic [3:0] EXE_SRL = 4'b1010;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEZ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JMP  = 2'b11;

    typedef struct packed {
        logic       wb;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] branch;
        logic [3:0] exe_cmd;
        logic       imm;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = 10'b0;

    function automatic ctrl_bundle_t mk_ctrl(input logic wb, input logic mr, input logic mw,
                                             input logic [1:0] br, input logic [3:0] cmd,
                                             input logic imm);
        ctrl_bundle_t c;
        c.wb        = wb;
        c.mem_read  = mr;
        c.mem_write = mw;
        c.branch    = br;
        c.exe_cmd   = cmd;
        c.imm       = imm;
        return c;
    endfunction

endpackage

// File: rtl/op_decoder.sv
// Combinational opcode decoder: control bundle, source-register usage and
// an unmapped-opcode indication.
module op_decoder
    import ctrl_pkg::*;
(
    input  logic [CTRL_OPCODE_W-1:0] opcode_i,
    output ctrl_bundle_t             ctrl_o,
    output logic                     uses_src1_o,
    output logic                     uses_src2_o,
    output logic                     illegal_o
);

    // Opcode to control-bundle map; unmapped opcodes behave as NOP
    always_comb begin
        ctrl_o      = CTRL_BUBBLE;
        uses_src1_o = 1'b0;
        uses_src2_o = 1'b0;
        illegal_o   = 1'b0;
        case (opcode_i)
            OP_NOP: begin
                ctrl_o = CTRL_BUBBLE;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR,
            OP_SLA, OP_SLL, OP_SRA, OP_SRL: begin
                uses_src1_o = 1'b1;
                uses_src2_o = 1'b1;
                case (opcode_i)
                    OP_ADD:  ctrl_o = mk_ctrl(1'b1, 1'b0, 1'b0, BR_NONE, EXE_ADD, 1'b0);
                    OP_SUB:  ctrl_o = mk_ctrl(1'b1, 1'b0, 1'b0, BR_NONE, EXE_SUB, 1'b0);
                    OP_AND:  ctrl_o = mk_ctrl(1'b1, 1'b0, 1'b0, BR_NONE, EXE_AND, 1'b0);
                    OP_OR:   ctrl_o = mk_ctrl(1'b1, 1'b0, 1'b0, BR_NONE, EXE_OR,  1'b0);
                    OP_NOR:  ctrl_o = mk_ctrl(1'b1, 1'b0, 1'b0, BR_NONE, EXE_NOR, 1'b0);
                    OP_XOR:  ctrl_o = mk_ctrl(1'b1, 1'b0, 1'b0, BR_NONE, EXE_XOR, 1'b0);
                    OP_SRA:  ctrl_o = mk_ctrl(1'b1, 1'b0, 1'b0, BR_NONE, EXE_SRA, 1'b0);
                    OP_SRL:  ctrl_o = mk_ctrl(1'b1, 1'b0, 1'b0, BR_NONE, EXE_SRL, 1'b0);
                    default: ctrl_o = mk_ctrl(1'b1, 1'b0, 1'b0, BR_NONE, EXE_SHL, 1'b0);
                endcase
            end
            OP_ADDI: begin
                uses_src1_o = 1'b1;
                ctrl_o      = mk_ctrl(1'b1, 1'b0, 1'b0, BR_NONE, EXE_ADD, 1'b1);
            end
            OP_SUBI: begin
                uses_src1_o = 1'b1;
                ctrl_o      = mk_ctrl(1'b1, 1'b0, 1'b0, BR_NONE, EXE_SUB, 1'b1);
            end
            OP_LD: begin
                uses_src1_o = 1'b1;
                ctrl_o      = mk_ctrl(1'b1, 1'b1, 1'b0, BR_NONE, EXE_ADD, 1'b1);
            end
            OP_ST: begin
                uses_src1_o = 1'b1;
                uses_src2_o = 1'b1;
                ctrl_o      = mk_ctrl(1'b0, 1'b0, 1'b1, BR_NONE, EXE_ADD, 1'b1);
            end
            OP_BEZ: begin
                uses_src1_o = 1'b1;
                ctrl_o      = mk_ctrl(1'b0, 1'b0, 1'b0, BR_BEZ, EXE_ADD, 1'b1);
            end
            OP_BNE: begin
                uses_src1_o = 1'b1;
                uses_src2_o = 1'b1;
                ctrl_o      = mk_ctrl(1'b0, 1'b0, 1'b0, BR_BNE, EXE_ADD, 1'b1);
            end
            OP_JMP: begin
                ctrl_o = mk_ctrl(1'b0, 1'b0, 1'b0, BR_JMP, EXE_ADD, 1'b1);
            end
            default: begin
                ctrl_o    = CTRL_BUBBLE;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_stage.sv
// ID-stage control: decode, load-use hazard detection and the ID/EX control
// register. Define CTRL_ILLEGAL_TRAP_EN to bubble unmapped opcodes and raise illegal_op.
module pipe_ctrl_stage
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W   = CTRL_OPCODE_W,
    parameter int EXE_CMD_W  = CTRL_EXE_CMD_W,
    parameter int REG_ADDR_W = CTRL_REG_ADDR_W
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [OPCODE_W-1:0]   id_opcode,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  freeze,
    input  logic                  flush,
    output logic                  hazard_stall,
    output logic                  ex_valid,
    output logic                  ex_wb_en,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic [1:0]            ex_branch_type,
    output logic [EXE_CMD_W-1:0]  ex_exe_cmd,
    output logic                  ex_is_imm,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic                  illegal_op
);

    ctrl_bundle_t          dec_ctrl_s;
    logic                  dec_us1_s;
    logic                  dec_us2_s;
    logic                  dec_illegal_s;
    logic                  src_hit_s;
    logic                  trap_s;
    logic                  bubble_s;

    ctrl_bundle_t          ctrl_d, ctrl_q;
    logic                  valid_d, valid_q;
    logic [REG_ADDR_W-1:0] dest_d, dest_q;
    logic                  illegal_d, illegal_q;

    op_decoder u_dec (
        .opcode_i    (id_opcode),
        .ctrl_o      (dec_ctrl_s),
        .uses_src1_o (dec_us1_s),
        .uses_src2_o (dec_us2_s),
        .illegal_o   (dec_illegal_s)
    );

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign trap_s = id_valid & dec_illegal_s;
`else
    logic unused_illegal_s;
    assign unused_illegal_s = dec_illegal_s;
    assign trap_s           = 1'b0;
`endif

    // Register 0 is never a real producer, so it cannot create a load-use hazard
    assign src_hit_s = (dec_us1_s & (id_src1 == dest_q)) | (dec_us2_s & (id_src2 == dest_q));
    assign hazard_stall = ~freeze & id_valid & valid_q & ctrl_q.mem_read &
                          (dest_q != {REG_ADDR_W{1'b0}}) & src_hit_s;

    assign bubble_s  = flush | hazard_stall | ~id_valid | trap_s;
    assign illegal_d = illegal_q | (~freeze & ~flush & trap_s);

    // Next ID/EX contents: freeze holds, then bubble, then the decoded instruction
    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        dest_d  = dest_q;
        if (freeze) begin
            ctrl_d  = ctrl_q;
            valid_d = valid_q;
            dest_d  = dest_q;
        end else if (bubble_s) begin
            ctrl_d  = CTRL_BUBBLE;
            valid_d = 1'b0;
            dest_d  = {REG_ADDR_W{1'b0}};
        end else begin
            ctrl_d  = dec_ctrl_s;
            valid_d = 1'b1;
            dest_d  = id_dest;
        end
    end

    // ID/EX control pipeline register and sticky illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= CTRL_BUBBLE;
            valid_q   <= 1'b0;
            dest_q    <= {REG_ADDR_W{1'b0}};
            illegal_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            dest_q    <= dest_d;
            illegal_q <= illegal_d;
        end
    end

    assign ex_valid       = valid_q;
    assign ex_wb_en       = ctrl_q.wb;
    assign ex_mem_read    = ctrl_q.mem_read;
    assign ex_mem_write   = ctrl_q.mem_write;
    assign ex_branch_type = ctrl_q.branch;
    assign ex_exe_cmd     = ctrl_q.exe_cmd;
    assign ex_is_imm      = ctrl_q.imm;
    assign ex_dest        = dest_q;
    assign illegal_op     = illegal_q;

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// Self-checking bench for pipe_ctrl_stage: directed cases from the plan plus
// randomized traffic against a table-driven reference model.
module tb_pipe_ctrl_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [5:0] id_opcode = 6'd0;
    logic [4:0] id_src1 = 5'd0, id_src2 = 5'd0, id_dest = 5'd0;
    logic       freeze = 1'b0, flush = 1'b0;
    logic       hazard_stall, ex_valid, ex_wb_en, ex_mem_read, ex_mem_write, ex_is_imm, illegal_op;
    logic [1:0] ex_branch_type;
    logic [3:0] ex_exe_cmd;
    logic [4:0] ex_dest;

    int chk_cnt = 0;
    int pass_cnt = 0;

    pipe_ctrl_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_src1(id_src1), .id_src2(id_src2), .id_dest(id_dest),
        .freeze(freeze), .flush(flush), .hazard_stall(hazard_stall),
        .ex_valid(ex_valid), .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch_type(ex_branch_type),
        .ex_exe_cmd(ex_exe_cmd), .ex_is_imm(ex_is_imm), .ex_dest(ex_dest),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // Decode reference table, indexed by opcode
    bit       t_map[64];
    bit       t_wb[64], t_mr[64], t_mw[64], t_imm[64], t_us1[64], t_us2[64];
    bit [1:0] t_br[64];
    bit [3:0] t_cmd[64];

    // Expected EX-slot contents
    bit       m_valid, m_wb, m_mr, m_mw, m_imm, m_ill;
    bit [1:0] m_br;
    bit [3:0] m_cmd;
    bit [4:0] m_dest;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic def_op(input int op, input bit wb, input bit mr, input bit mw,
                          input bit [1:0] br, input bit [3:0] cmd, input bit imm,
                          input bit u1, input bit u2);
        t_map[op] = 1'b1; t_wb[op] = wb; t_mr[op] = mr; t_mw[op] = mw;
        t_br[op] = br; t_cmd[op] = cmd; t_imm[op] = imm; t_us1[op] = u1; t_us2[op] = u2;
    endtask

    task automatic model_clear();
        m_valid = 0; m_wb = 0; m_mr = 0; m_mw = 0; m_imm = 0; m_br = 0; m_cmd = 0; m_dest = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_valid"}, ex_valid, m_valid);
        chk({tag, "_wb"}, ex_wb_en, m_wb);
        chk({tag, "_mr"}, ex_mem_read, m_mr);
        chk({tag, "_mw"}, ex_mem_write, m_mw);
        chk({tag, "_br"}, ex_branch_type, m_br);
        chk({tag, "_cmd"}, ex_exe_cmd, m_cmd);
        chk({tag, "_imm"}, ex_is_imm, m_imm);
        chk({tag, "_dest"}, ex_dest, m_dest);
        chk({tag, "_ill"}, illegal_op, m_ill);
    endtask

    // One ID cycle: drive, check the stall, clock, update model, check EX outputs
    task automatic step(input string tag, input bit v, input int op, input int s1, input int s2,
                        input int d, input bit frz, input bit fl);
        bit exp_stall;
        @(negedge clk);
        id_valid = v; id_opcode = op[5:0]; id_src1 = s1[4:0]; id_src2 = s2[4:0];
        id_dest = d[4:0]; freeze = frz; flush = fl;
        #1;
        exp_stall = !frz && v && m_valid && m_mr && (m_dest != 0) &&
                    ((t_us1[op] && s1 == m_dest) || (t_us2[op] && s2 == m_dest));
        chk({tag, "_stall"}, hazard_stall, exp_stall);
        @(posedge clk);
        if (!frz) begin
            if (v && !fl && TRAP && !t_map[op]) m_ill = 1;
            if (fl || exp_stall || !v || (TRAP && !t_map[op])) model_clear();
            else begin
                m_valid = 1; m_wb = t_wb[op]; m_mr = t_mr[op]; m_mw = t_mw[op];
                m_br = t_br[op]; m_cmd = t_cmd[op]; m_imm = t_imm[op]; m_dest = d[4:0];
            end
        end
        #1;
        check_outputs(tag);
    endtask

    int rop;
    int op_pool[18] = '{0, 1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 32, 33, 36, 37, 40, 41, 42};

    initial begin
        def_op(0, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 0);
        def_op(1, 1, 0, 0, 2'b00, 4'b0000, 0, 1, 1);
        def_op(3, 1, 0, 0, 2'b00, 4'b0010, 0, 1, 1);
        def_op(5, 1, 0, 0, 2'b00, 4'b0100, 0, 1, 1);
        def_op(6, 1, 0, 0, 2'b00, 4'b0101, 0, 1, 1);
        def_op(7, 1, 0, 0, 2'b00, 4'b0110, 0, 1, 1);
        def_op(8, 1, 0, 0, 2'b00, 4'b0111, 0, 1, 1);
        def_op(9, 1, 0, 0, 2'b00, 4'b1000, 0, 1, 1);
        def_op(10, 1, 0, 0, 2'b00, 4'b1000, 0, 1, 1);
        def_op(11, 1, 0, 0, 2'b00, 4'b1001, 0, 1, 1);
        def_op(12, 1, 0, 0, 2'b00, 4'b1010, 0, 1, 1);
        def_op(32, 1, 0, 0, 2'b00, 4'b0000, 1, 1, 0);
        def_op(33, 1, 0, 0, 2'b00, 4'b0010, 1, 1, 0);
        def_op(36, 1, 1, 0, 2'b00, 4'b0000, 1, 1, 0);
        def_op(37, 0, 0, 1, 2'b00, 4'b0000, 1, 1, 1);
        def_op(40, 0, 0, 0, 2'b01, 4'b0000, 1, 1, 0);
        def_op(41, 0, 0, 0, 2'b10, 4'b0000, 1, 1, 1);
        def_op(42, 0, 0, 0, 2'b11, 4'b0000, 1, 0, 0);
        model_clear();
        m_ill = 0;

        #12;
        check_outputs("rst");
        @(negedge clk) rst_n = 1'b1;

        // Asynchronous reset in mid-stream
        step("pre_a", 1, 1, 1, 2, 7, 0, 0);
        step("pre_b", 1, 36, 1, 2, 9, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_clear(); m_ill = 0;
        check_outputs("midrst");
        @(negedge clk) rst_n = 1'b1;
        step("post_rst", 1, 1, 1, 2, 6, 0, 0);
        chk("post_rst_addwb", ex_wb_en, 1'b1);

        // Load-use: stall one cycle, bubble, then SUB issues
        step("lu_ld", 1, 36, 1, 0, 3, 0, 0);
        step("lu_sub1", 1, 3, 3, 5, 8, 0, 0);
        chk("lu_bubble", ex_valid, 1'b0);
        step("lu_sub2", 1, 3, 3, 5, 8, 0, 0);
        chk("lu_sub_cmd", ex_exe_cmd, 4'b0010);

        // Register 0 and immediate operand
        step("r0_ld", 1, 36, 1, 0, 0, 0, 0);
        step("r0_add", 1, 1, 0, 0, 4, 0, 0);
        step("imm_ld", 1, 36, 1, 0, 4, 0, 0);
        step("imm_addi", 1, 32, 2, 4, 5, 0, 0);
        chk("imm_nostall_valid", ex_valid, 1'b1);

        // Flush, then flush held under freeze
        step("fl_add", 1, 1, 1, 2, 3, 0, 0);
        step("fl_bne", 1, 41, 1, 2, 0, 0, 1);
        step("fz_add", 1, 1, 1, 2, 3, 0, 0);
        step("fz_hold1", 1, 41, 1, 2, 0, 1, 1);
        step("fz_hold2", 1, 41, 1, 2, 0, 1, 1);
        step("fz_release", 1, 41, 1, 2, 0, 0, 1);

        // Decode sweep over all 64 opcodes
        for (int op = 0; op < 64; op++) step($sformatf("sweep%0d", op), 1, op, 6, 7, 9, 0, 0);
        chk("ill_sticky", illegal_op, TRAP);
        step("ill_hold", 1, 1, 1, 2, 3, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) rop = $urandom_range(0, 63);
            else rop = op_pool[$urandom_range(0, 17)];
            if ($urandom_range(0, 4) == 0) rop = 36;
            step("rnd", ($urandom_range(0, 9) != 0), rop, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_stage.md
Name: pipe_ctrl_stage

Overview:
- Second-generation control unit for the 5-stage pipeline.
- Decodes the ID-stage opcode into control bundles and registers them into the ID/EX control pipeline register.
- Detects load-use hazards against the instruction currently in EX.
- Inserts bubbles on stall or branch flush, and holds state on a global freeze.
- Sits between the instruction register and the EX stage; all EX-side control comes only from this block's registered outputs.

Parameters:
- OPCODE_W, 6, opcode width.
- EXE_CMD_W, 4, ALU command width.
- REG_ADDR_W, 5, register-address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  OPCODE_W  ID opcode
- id_src1  in  REG_ADDR_W  first source register
- id_src2  in  REG_ADDR_W  second source register
- id_dest  in  REG_ADDR_W  destination register
- freeze  in  1  global pipeline hold (memory wait)
- flush  in  1  branch taken in EX; kill the ID instruction
- hazard_stall  out  1  combinational; stall PC/IF/ID this cycle
- ex_valid  out  1  registered: EX slot holds a real instruction
- ex_wb_en  out  1  registered control to EX
- ex_mem_read  out  1  registered control to EX
- ex_mem_write  out  1  registered control to EX
- ex_branch_type  out  2  registered: 00 none, 01 BEZ, 10 BNE, 11 JMP
- ex_exe_cmd  out  EXE_CMD_W  registered ALU command
- ex_is_imm  out  1  registered immediate-operand select
- ex_dest  out  REG_ADDR_W  registered destination register
- illegal_op  out  1  sticky flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low. While rst_n=0, every registered output and illegal_op is 0.
- Decode map: opcode -> {wb, mem_read, mem_write, branch, exe_cmd, imm}
  - 0 NOP: all 0
  - 1 ADD: wb, exe 0000
  - 3 SUB: wb, 0010
  - 5 AND: wb, 0100
  - 6 OR: wb, 0101
  - 7 NOR: wb, 0110
  - 8 XOR: wb, 0111
  - 9 SLA and 10 SLL: wb, 1000
  - 11 SRA: wb, 1001
  - 12 SRL: wb, 1010
  - 32 ADDI: wb, 0000, imm
  - 33 SUBI: wb, 0010, imm
  - 36 LD: wb, mem_read, 0000, imm
  - 37 ST: mem_write, 0000, imm
  - 40 BEZ: branch 01, imm
  - 41 BNE: branch 10, imm
  - 42 JMP: branch 11, imm
  - All other opcodes decode as NOP.
- Source usage:
  - uses_src1 is 1 for every opcode except NOP and JMP.
  - uses_src2 is 1 for R-type opcodes (1..12), ST and BNE.
- hazard_stall is 1 when all of the following hold:
  - id_valid & ex_valid & ex_mem_read;
  - ex_dest != 0;
  - (uses_src1 & id_src1==ex_dest) | (uses_src2 & id_src2==ex_dest).
  - Register 0 never causes a hazard.
  - hazard_stall is forced to 0 while freeze=1.
- ID/EX register update at each rising edge, highest priority first:
  1. freeze=1: hold all registered outputs.
  2. flush=1, hazard_stall=1 or id_valid=0: load a bubble (all controls 0, ex_valid=0, ex_dest=0).
  3. Otherwise: load the decoded bundle, ex_valid=1, ex_dest=id_dest.
- Latency: 1 cycle from ID to the ex_* outputs.
- A stall lasts exactly 1 cycle: the bubble clears ex_mem_read on the next edge.
- flush asserted together with freeze: freeze wins. The EX stage is frozen too, so flush stays asserted and is honoured on the first unfrozen edge.
- Reset asserted mid-operation clears the register immediately; the first post-reset edge behaves per the normal update rules.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An unmapped opcode with id_valid=1 loads a bubble and sets illegal_op.
  - illegal_op stays set until reset.
  - Stall and freeze rules are unchanged; a frozen or flushed cycle never sets the flag.
- Undefined: unmapped opcodes decode silently as NOP and illegal_op is tied to 0.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams, OP_ADD through OP_JMP;
  - EXE_CMD constants;
  - BR_NONE, BR_BEZ, BR_BNE, BR_JMP;
  - a packed control-bundle struct {wb, mem_read, mem_write, branch, exe_cmd, imm}.
- Sub-module op_decoder: purely combinational. Takes the opcode and returns the control bundle, uses_src1, uses_src2 and illegal.
- The top level holds the hazard comparator, the ID/EX register and the sticky flag.

Test Plan:
- Reset: pulse rst_n low mid-stream with a valid ADD in ID -> all ex_* outputs 0 asynchronously; the ADD appears (ex_exe_cmd=0000, ex_wb_en=1) one edge after release.
- Load-use: LD r3 in EX, SUB with src1=r3 in ID -> hazard_stall=1 for exactly 1 cycle, bubble (ex_valid=0), then SUB issues with ex_exe_cmd=0010.
- Register-0 and immediate cases:
  - LD r0 followed by ADD r0,r0 -> no stall.
  - LD r4 followed by ADDI with src2=r4 -> no stall.
- Flush: flush=1 with BNE in ID -> ex_branch_type=00 and ex_valid=0 next cycle. The same flush held under freeze=1 -> outputs hold, and the bubble loads on the first edge after freeze drops.
- Decode sweep: all 64 opcodes -> bundles match the map; JMP gives branch 11; ST gives mem_write=1 and wb=0. With CTRL_ILLEGAL_TRAP_EN, opcode 63 sets illegal_op sticky; without it, illegal_op stays 0.
